// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } imem_rsp_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  function automatic imem_rsp_t imem_rsp_idle();
    imem_rsp_t r;
    r.pc   = RESET_PC;
    r.inst = '0;
    r.err  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response and program-load signals of the instruction memory.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_pc;
  logic        rsp_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_wdata,
    input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_wdata,
    output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_err
  );
endinterface

// File: rtl/imem_rsp_fifo.sv
// Circular response buffer; pointers carry one extra wrap bit to tell full from empty.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      push_i,
  input  imem_rsp_t wdata_i,
  input  logic      pop_i,
  output imem_rsp_t rdata_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [IdxW:0] count_o
);

  logic [IdxW:0] wr_q, wr_d, rd_q, rd_d;
  imem_rsp_t     mem_q [Depth];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[IdxW] != rd_q[IdxW]) && (wr_q[IdxW-1:0] == rd_q[IdxW-1:0]);
  assign count_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[IdxW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q[IdxW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: array, fixed-latency read pipe, credit-limited response buffer.
// Optional IMEM_ALIGN_CHK_EN flags misaligned fetch addresses as errors.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RESP_DEPTH  = 2
) (
  input logic             clk,
  input logic             nrst,
  imem_responder_if.slave bus_io
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned IdxW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = $clog2(RESP_DEPTH + LATENCY + 1);

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [AW-1:0]   req_idx, prog_idx;
  logic            req_in_range, prog_in_range, req_misal;
  imem_rsp_t       req_rsp;
  logic            ready_en_q;
  logic [CntW-1:0] pipe_cnt, outstanding;
  logic            accept, push_vld, push, pop;
  imem_rsp_t       push_dat, head, last_q;
  logic            fifo_full, fifo_empty;
  logic [IdxW:0]   fifo_cnt;

  assign req_idx       = bus_io.req_addr[AW+1:2];
  assign prog_idx      = bus_io.prog_addr[AW+1:2];
  assign req_in_range  = ~|bus_io.req_addr[31:AW+2];
  assign prog_in_range = ~|bus_io.prog_addr[31:AW+2];

`ifdef IMEM_ALIGN_CHK_EN
  logic unused_addr_lsb;
  assign req_misal       = |bus_io.req_addr[1:0];
  assign unused_addr_lsb = ^bus_io.prog_addr[1:0];
`else
  logic unused_addr_lsb;
  assign req_misal       = 1'b0;
  assign unused_addr_lsb = ^{bus_io.req_addr[1:0], bus_io.prog_addr[1:0]};
`endif

  always_comb begin
    req_rsp.pc   = bus_io.req_addr;
    req_rsp.err  = ~req_in_range | req_misal;
    req_rsp.inst = req_rsp.err ? NOP_INST : mem_q[req_idx];
  end

  // Program writes land on the edge, so a same-cycle fetch still sees the old word.
  always_ff @(posedge clk) begin
    if (bus_io.prog_we && prog_in_range) mem_q[prog_idx] <= bus_io.prog_wdata;
  end

  // Holds req_ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ready_en_q <= 1'b0;
    else       ready_en_q <= 1'b1;
  end

  assign outstanding      = pipe_cnt + CntW'(fifo_cnt);
  assign bus_io.req_ready = ready_en_q & (outstanding < CntW'(RESP_DEPTH)) & ~bus_io.flush;
  assign accept           = bus_io.req_valid & bus_io.req_ready;

  // The buffer write is the final latency stage, so LATENCY-1 registered stages remain.
  if (LATENCY == 1) begin : g_no_pipe
    assign push_vld = accept;
    assign push_dat = req_rsp;
    assign pipe_cnt = '0;
  end else begin : g_pipe
    localparam int unsigned Stages = LATENCY - 1;
    logic [Stages-1:0] vld_q, vld_d;
    imem_rsp_t         dat_q [Stages];
    imem_rsp_t         dat_d [Stages];

    always_comb begin
      vld_d[0] = accept;
      dat_d[0] = req_rsp;
      for (int i = 1; i < int'(Stages); i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
      if (bus_io.flush) vld_d = '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        vld_q <= '0;
        for (int i = 0; i < int'(Stages); i++) dat_q[i] <= imem_rsp_idle();
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < int'(Stages); i++) pipe_cnt = pipe_cnt + CntW'(vld_q[i]);
    end

    assign push_vld = vld_q[Stages-1] & ~bus_io.flush;
    assign push_dat = dat_q[Stages-1];
  end

  assign pop  = ~fifo_empty & bus_io.rsp_ready;
  assign push = push_vld & (~fifo_full | pop);

  imem_rsp_fifo #(
    .Depth(RESP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (nrst),
    .flush_i (bus_io.flush),
    .push_i  (push),
    .wdata_i (push_dat),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Tracks the head so the outputs keep their last value once the buffer drains.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)            last_q <= imem_rsp_idle();
    else if (!fifo_empty) last_q <= head;
  end

  assign bus_io.rsp_valid = ~fifo_empty;
  assign bus_io.rsp_inst  = fifo_empty ? last_q.inst : head.inst;
  assign bus_io.rsp_pc    = fifo_empty ? last_q.pc   : head.pc;
  assign bus_io.rsp_err   = fifo_empty ? last_q.err  : head.err;

endmodule
